// File: rtl/ddr4_phy_pkg.sv
// Shared DDR4 PHY training types and width helpers (used by ddr4_fsm and ddr4_fine_train).
package ddr4_phy_pkg;

    localparam int LANES_DEF        = 16;
    localparam int DELAY_TAPS_DEF   = 64;
    localparam int COARSE_STEPS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE, SET_TAP, SETTLE, SAMPLE, EVAL, FINISH
    } fine_state_t;

    function automatic int tap_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    function automatic int wid_w(input int taps);
        return $clog2(taps + 1);
    endfunction

    function automatic int sel_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    localparam int TAP_W = tap_w(DELAY_TAPS_DEF);
    localparam int WID_W = wid_w(DELAY_TAPS_DEF);
    localparam int SEL_W = sel_w(COARSE_STEPS_DEF);

endpackage

// File: rtl/ddr4_lane_window.sv
// One lane of the fine eye search: ok counter, open-run tracker and best-run tracker.
// DDR4_FINE_MAJORITY_EN relaxes the per-tap pass rule to a majority of samples.
module ddr4_lane_window #(
    parameter int TAP_W     = 6,
    parameter int WID_W     = 7,
    parameter int SAMPLES   = 4,
    parameter int MIN_WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             sample_i,
    input  logic             eval_i,
    input  logic             last_i,
    input  logic             finish_i,
    input  logic [TAP_W-1:0] tap_i,
    input  logic             read_ok_i,
    output logic             valid_d_o,
    output logic             lane_valid_o,
    output logic [TAP_W-1:0] best_start_o,
    output logic [TAP_W-1:0] best_end_o,
    output logic [WID_W-1:0] best_width_o
);

    localparam int OK_W = $clog2(SAMPLES + 1);
`ifdef DDR4_FINE_MAJORITY_EN
    localparam int PASS_MIN = SAMPLES / 2 + 1;
`else
    localparam int PASS_MIN = SAMPLES;
`endif
    localparam logic [OK_W-1:0]  PASS_TH = OK_W'(PASS_MIN);
    localparam logic [WID_W-1:0] MIN_W   = WID_W'(MIN_WIDTH);

    logic [OK_W-1:0]  ok_q;
    logic [TAP_W-1:0] run_start_q, run_start_d, best_start_q;
    logic [WID_W-1:0] run_len_q, run_len_d, best_len_q;
    logic             pass, close;

    assign pass      = (ok_q >= PASS_TH);
    assign close     = !pass || last_i;
    assign valid_d_o = (best_len_q >= MIN_W);

    always_comb begin
        run_start_d = run_start_q;
        run_len_d   = run_len_q;
        if (pass) begin
            if (run_len_q == '0) run_start_d = tap_i;
            run_len_d = run_len_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_q         <= '0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            lane_valid_o <= 1'b0;
            best_start_o <= '0;
            best_end_o   <= '0;
            best_width_o <= '0;
        end else if (clear_i) begin
            ok_q         <= '0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            lane_valid_o <= 1'b0;
            best_start_o <= '0;
            best_end_o   <= '0;
            best_width_o <= '0;
        end else begin
            if (sample_i && read_ok_i) ok_q <= ok_q + 1'b1;
            if (eval_i) begin
                ok_q <= '0;
                if (close) begin
                    // strict compare: an equal later run never displaces the earlier one
                    run_len_q <= '0;
                    if (run_len_d > best_len_q) begin
                        best_start_q <= run_start_d;
                        best_len_q   <= run_len_d;
                    end
                end else begin
                    run_start_q <= run_start_d;
                    run_len_q   <= run_len_d;
                end
            end
            if (finish_i) begin
                lane_valid_o <= valid_d_o;
                best_width_o <= best_len_q;
                best_start_o <= (best_len_q != '0) ? best_start_q : '0;
                best_end_o   <= (best_len_q != '0) ?
                                best_start_q + best_len_q[TAP_W-1:0] - 1'b1 : '0;
            end
        end
    end

endmodule

// File: rtl/ddr4_fine_train.sv
// Fine read-eye sweep: steps the delay tap across a coarse region and reports the best
// passing window per lane. Optional build macro: DDR4_FINE_MAJORITY_EN (in ddr4_lane_window).
module ddr4_fine_train
    import ddr4_phy_pkg::*;
#(
    parameter int LANES         = LANES_DEF,
    parameter int DELAY_TAPS    = DELAY_TAPS_DEF,
    parameter int COARSE_STEPS  = COARSE_STEPS_DEF,
    parameter int SWEEP_SPAN    = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int SAMPLES       = 4,
    parameter int MIN_WIDTH     = 6,
    localparam int TAP_W = tap_w(DELAY_TAPS),
    localparam int WID_W = wid_w(DELAY_TAPS),
    localparam int SEL_W = sel_w(COARSE_STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fine_start,
    input  logic [SEL_W-1:0] coarse_sel,
    input  logic [LANES-1:0] read_ok,
    output logic [TAP_W-1:0] fine_tap,
    output logic             busy,
    output logic             fine_done,
    output logic             fine_failed,
    output logic [LANES-1:0] lane_valid,
    output logic [TAP_W-1:0] best_start [LANES],
    output logic [TAP_W-1:0] best_end   [LANES],
    output logic [WID_W-1:0] best_width [LANES]
);

    localparam int STEP    = DELAY_TAPS / COARSE_STEPS;
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HI_W    = WID_W + 1;
    localparam logic [HI_W-1:0]  SPAN_M1     = HI_W'(SWEEP_SPAN - 1);
    localparam logic [HI_W-1:0]  TOP_TAP     = HI_W'(DELAY_TAPS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLES - 1);

    fine_state_t      state_q;
    logic [TAP_W-1:0] tap_q, fine_tap_q;
    logic [HI_W-1:0]  hi_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q, failed_q;

    logic [HI_W-1:0]  lo_w, hi_w, end_w;
    logic             accept, at_hi;
    logic [LANES-1:0] lane_ok_d;

    // extra bit so lo+SPAN-1 in the top region cannot wrap before clamping
    assign lo_w   = HI_W'(coarse_sel) * HI_W'(STEP);
    assign end_w  = lo_w + SPAN_M1;
    assign hi_w   = (end_w > TOP_TAP) ? TOP_TAP : end_w;
    assign accept = (state_q == IDLE) && fine_start;
    assign at_hi  = (HI_W'(tap_q) == hi_q);

    assign fine_tap    = fine_tap_q;
    assign busy        = busy_q;
    assign fine_done   = done_q;
    assign fine_failed = failed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tap_q      <= '0;
            hi_q       <= '0;
            cnt_q      <= '0;
            fine_tap_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            failed_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            failed_q <= 1'b0;
            case (state_q)
                IDLE: if (fine_start) begin
                    tap_q   <= lo_w[TAP_W-1:0];
                    hi_q    <= hi_w;
                    busy_q  <= 1'b1;
                    state_q <= SET_TAP;
                end
                SET_TAP: begin
                    fine_tap_q <= tap_q;
                    cnt_q      <= '0;
                    state_q    <= SETTLE;
                end
                SETTLE: if (cnt_q == SETTLE_LAST) begin
                    cnt_q   <= '0;
                    state_q <= SAMPLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                SAMPLE: if (cnt_q == SAMPLE_LAST) state_q <= EVAL;
                        else cnt_q <= cnt_q + 1'b1;
                EVAL: if (at_hi) begin
                    state_q <= FINISH;
                end else begin
                    tap_q   <= tap_q + 1'b1;
                    state_q <= SET_TAP;
                end
                FINISH: begin
                    done_q   <= &lane_ok_d;
                    failed_q <= ~&lane_ok_d;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ddr4_lane_window #(
            .TAP_W    (TAP_W),
            .WID_W    (WID_W),
            .SAMPLES  (SAMPLES),
            .MIN_WIDTH(MIN_WIDTH)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear_i     (accept),
            .sample_i    (state_q == SAMPLE),
            .eval_i      (state_q == EVAL),
            .last_i      (at_hi),
            .finish_i    (state_q == FINISH),
            .tap_i       (tap_q),
            .read_ok_i   (read_ok[g]),
            .valid_d_o   (lane_ok_d[g]),
            .lane_valid_o(lane_valid[g]),
            .best_start_o(best_start[g]),
            .best_end_o  (best_end[g]),
            .best_width_o(best_width[g])
        );
    end

endmodule

// File: tb/tb_ddr4_fine_train.sv
// Directed plus randomized windows against a per-lane longest-run reference model.
module tb_ddr4_fine_train;

    localparam int LANES = 16;
    localparam int STEP  = 8;
    localparam int SPAN  = 32;
    localparam int MINW  = 6;
    localparam int TPC   = 8;
`ifdef DDR4_FINE_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fine_start = 1'b0;
    logic [2:0]       coarse_sel = '0;
    logic [LANES-1:0] read_ok = '0;
    logic [5:0]       fine_tap;
    logic             busy, fine_done, fine_failed;
    logic [LANES-1:0] lane_valid;
    logic [5:0]       best_start [LANES];
    logic [5:0]       best_end   [LANES];
    logic [6:0]       best_width [LANES];

    ddr4_fine_train dut (
        .clk(clk), .rst_n(rst_n), .fine_start(fine_start), .coarse_sel(coarse_sel),
        .read_ok(read_ok), .fine_tap(fine_tap), .busy(busy), .fine_done(fine_done),
        .fine_failed(fine_failed), .lane_valid(lane_valid), .best_start(best_start),
        .best_end(best_end), .best_width(best_width)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] pat [LANES];
    int          glitch_tap = -1;
    int          age = 0;
    int          last_tap = -1;

    // read_ok follows the tap; the glitch drops one sample (second sample cycle) at glitch_tap
    always @(negedge clk) begin
        if (int'(fine_tap) != last_tap) begin
            last_tap = int'(fine_tap);
            age = 0;
        end else begin
            age++;
        end
        for (int l = 0; l < LANES; l++)
            read_ok[l] = pat[l][fine_tap] && !(int'(fine_tap) == glitch_tap && age == 3);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] win(input int a, input int b);
        logic [63:0] m = '0;
        for (int t = a; t <= b && t < 64; t++) m[t] = 1'b1;
        return m;
    endfunction

    function automatic bit tap_pass(input int l, input int t);
        if (t == glitch_tap && !MAJ) return 1'b0;
        return pat[l][t];
    endfunction

    // longest contiguous passing run in [lo,hi], earliest wins ties
    task automatic model(input int l, input int lo, input int hi,
                         output int bs, output int be, output int bw);
        int cur = 0, cs = 0;
        bs = 0; bw = 0;
        for (int t = lo; t <= hi + 1; t++) begin
            if (t <= hi && tap_pass(l, t)) begin
                if (cur == 0) cs = t;
                cur++;
            end else begin
                if (cur > bw) begin bw = cur; bs = cs; end
                cur = 0;
            end
        end
        be = (bw > 0) ? bs + bw - 1 : 0;
    endtask

    task automatic run(input int sel, input bit poke);
        int lo, hi, n, bs, be, bw;
        bit got, all_ok;
        logic [6:0] held;
        lo = sel * STEP;
        hi = (lo + SPAN - 1 > 63) ? 63 : lo + SPAN - 1;
        @(negedge clk);
        coarse_sel = 3'(sel);
        fine_start = 1'b1;
        @(posedge clk); #1;
        fine_start = 1'b0;
        n = 1;
        check("busy_after_accept", busy, 1);
        check("clear_valid", lane_valid, 0);
        check("clear_width0", best_width[0], 0);
        got = 1'b0;
        while (n < 2000 && !got) begin
            if (poke && n == 20) fine_start = 1'b1;
            @(posedge clk); #1;
            fine_start = 1'b0;
            n++;
            if (fine_done || fine_failed) got = 1'b1;
        end
        check("latency", n, (hi - lo + 1) * TPC + 2);
        all_ok = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            model(l, lo, hi, bs, be, bw);
            all_ok &= (bw >= MINW);
            check($sformatf("start_l%0d", l), best_start[l], bs);
            check($sformatf("end_l%0d", l), best_end[l], be);
            check($sformatf("width_l%0d", l), best_width[l], bw);
            check($sformatf("valid_l%0d", l), lane_valid[l], (bw >= MINW));
        end
        check("done", fine_done, all_ok);
        check("failed", fine_failed, !all_ok);
        check("tap_at_hi", fine_tap, hi);
        held = best_width[3];
        repeat (3) @(posedge clk);
        #1;
        check("pulse_dropped", fine_done | fine_failed, 0);
        check("busy_idle", busy, 0);
        check("result_held", best_width[3], held);
    endtask

    task automatic fill(input int a, input int b);
        for (int l = 0; l < LANES; l++) pat[l] = win(a, b);
    endtask

    initial begin
        int pulses, sel, a, w;
        fill(64, 64);
        #12;
        check("rst_tap", fine_tap, 0);
        check("rst_busy", busy, 0);
        check("rst_done", fine_done, 0);
        check("rst_failed", fine_failed, 0);
        check("rst_valid", lane_valid, 0);
        check("rst_start7", best_start[7], 0);
        check("rst_end7", best_end[7], 0);
        check("rst_width7", best_width[7], 0);
        @(negedge clk);
        rst_n = 1'b1;

        // clean windows
        fill(10, 24);
        run(1, 1'b0);
        // two runs on lane 3: the longer later one wins
        fill(12, 20);
        pat[3] = win(9, 13) | win(16, 27);
        run(1, 1'b0);
        // equal runs: earliest wins
        pat[3] = win(9, 14) | win(20, 25);
        run(1, 1'b0);
        // one narrow lane fails the whole run
        fill(10, 24);
        pat[5] = win(30, 33);
        run(1, 1'b0);
        // top region, run still open at the last tap, start pulse while busy
        fill(58, 63);
        run(7, 1'b1);
        // single glitched sample inside the window
        fill(10, 24);
        glitch_tap = 17;
        run(1, 1'b0);
        glitch_tap = -1;

        for (int r = 0; r < 6; r++) begin
            sel = int'($urandom_range(0, 7));
            for (int l = 0; l < LANES; l++) begin
                a = sel * STEP + int'($urandom_range(0, 20));
                w = int'($urandom_range(3, 14));
                pat[l] = win(a, a + w - 1);
                if ($urandom_range(0, 1) == 1) begin
                    a = int'($urandom_range(0, 63));
                    pat[l] |= win(a, a + int'($urandom_range(0, 10)));
                end
            end
            run(sel, r[0]);
        end

        // reset in the middle of SAMPLE aborts silently
        fill(10, 24);
        @(negedge clk);
        coarse_sel = 3'd2;
        fine_start = 1'b1;
        @(posedge clk); #1;
        fine_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_tap", fine_tap, 0);
        check("midrst_done", fine_done, 0);
        check("midrst_failed", fine_failed, 0);
        check("midrst_width", best_width[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (300) begin
            @(posedge clk); #1;
            pulses += int'(fine_done) + int'(fine_failed);
        end
        check("midrst_no_pulse", pulses, 0);
        check("midrst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
